multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Next-generation multi-cycle control unit. Replaces the single-cycle opcode decoder with a Moore FSM.
//  Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and waits on a memory-ready handshake.
//  Counts retired instructions. Sits between instruction register and datapath muxes/strobes.
// PARAMETERS
//  OPCODE_W  6   opcode width; opcodes R=0, BEQ=1, LW=2, SW=3, J=4, others illegal
//  CNT_W     32  width of retired-instruction counter
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        synchronous active-high reset
//  Inst_opcode  in   OPCODE_W opcode from IR, sampled in DECODE
//  mem_ready    in   1        memory access complete this cycle
//  PCWrite      out  1        unconditional PC load
//  PCWriteCond  out  1        PC load if ALU zero
//  IorD         out  1        0=PC addr, 1=ALU addr
//  IRWrite      out  1        load IR
//  MemRead      out  1        memory read strobe
//  MemWrite     out  1        memory write strobe
//  MemtoReg     out  2        00=ALU, 01=MDR
//  RegDst       out  1        1=rd, 0=rt
//  RegWrite     out  1        register-file write
//  ALUSrcA      out  1        0=PC, 1=rs
//  ALUSrcB      out  2        00=rt, 01=const 1, 10=imm
//  ALUOp        out  2        00=add, 01=sub, 10=funct
//  PCSource     out  2        00=ALU, 01=ALUOut, 10=jump target
//  instr_done   out  1        one-cycle pulse on instruction retire
//  retired_cnt  out  CNT_W    retired-instruction count
//  illegal_op   out  1        sticky illegal-opcode flag
//  state        out  4        current state encoding
// BEHAVIOUR
//  - States: FETCH=0 DECODE=1 MEM_ADDR=2 MEM_RD=3 MEM_WB=4 MEM_WR=5 EXEC=6 R_WB=7 BRANCH=8 JUMP=9 TRAP=10.
//  - Reset: on the rst edge, state=FETCH, retired_cnt=0, illegal_op=0, op_q=0.
//  - While rst=1, every strobe/select output is forced to 0 combinationally.
//  - Outputs are Moore, decoded from state only; none is combinational from Inst_opcode.
//  - FETCH: MemRead=1, IorD=0, IRWrite=mem_ready, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, PCWrite=mem_ready.
//    Holds until mem_ready=1, then moves to DECODE.
//  - DECODE: latch op_q<=Inst_opcode; ALUSrcA=0, ALUSrcB=10 (branch target precompute).
//    Next state: R->EXEC, BEQ->BRANCH, LW/SW->MEM_ADDR, J->JUMP, other->see CONFIGURATION.
//  - MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: op_q=LW->MEM_RD, else MEM_WR.
//  - MEM_RD: MemRead=1, IorD=1. Holds until mem_ready, then MEM_WB.
//  - MEM_WB: RegWrite=1, RegDst=0, MemtoReg=01. Next: FETCH.
//  - MEM_WR: MemWrite=1, IorD=1. Holds until mem_ready, then FETCH.
//  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: R_WB.
//  - R_WB: RegWrite=1, RegDst=1, MemtoReg=00. Next: FETCH.
//  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next: FETCH.
//  - JUMP: PCWrite=1, PCSource=10. Next: FETCH.
//  - Retire: instr_done=1 in the final cycle of each instruction.
//    Final cycles: MEM_WB, MEM_WR with mem_ready, R_WB, BRANCH, JUMP.
//    retired_cnt increments on the same edge and wraps modulo 2^CNT_W.
//  - Latency with mem_ready tied high: LW=5, SW=4, R=4, BEQ=3, J=3 cycles.
//    Each cycle mem_ready is low adds one cycle in FETCH/MEM_RD/MEM_WR.
//  - Reset mid-instruction aborts the instruction: no retire, counter cleared, outputs 0 that cycle.
//  - Inst_opcode changes outside DECODE have no effect; op_q is used after DECODE.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined:
//    illegal opcode in DECODE -> TRAP; illegal_op=1 from the next cycle.
//    TRAP asserts no strobes, never retires, and is exited only by rst.
//  ILLEGAL_TRAP_EN undefined:
//    illegal opcode is a NOP: DECODE -> FETCH, instr_done=1, counter increments.
//    illegal_op is tied 0; the TRAP state is unreachable.
// TESTING
//  1 rst=1 for 2 cycles, mem_ready=1 -> state=0, retired_cnt=0, all strobes 0 during rst; FETCH after release.
//  2 LW (op=2), mem_ready=1 -> state sequence 0,1,2,3,4; MemtoReg=01 & RegWrite=1 in state 4; cnt=1.
//  3 SW (op=3), mem_ready low 3 cycles in MEM_WR -> MemWrite held 4 cycles, total 7, single instr_done.
//  4 R,BEQ,J back-to-back, mem_ready=1 -> 4+3+3=10 cycles, cnt=3, PCSource=10 in JUMP.
//  5 op=6'h3F -> TRAP_EN: state=10, illegal_op=1 until rst, cnt unchanged; no TRAP_EN: back to FETCH, cnt+1.
//  6 rst asserted in MEM_RD -> next state FETCH, no instr_done, cnt=0; preset cnt=2^CNT_W-1 then retire -> 0.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control unit: Moore FSM that sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB, waits on mem_ready, and counts retired instructions.
// Optional feature macro: ILLEGAL_TRAP_EN (illegal opcodes trap instead of NOP).
module multicycle_control_fsm #(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] Inst_opcode,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                IRWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic [1:0]          MemtoReg,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ALUOp,
  output logic [1:0]          PCSource,
  output logic                instr_done,
  output logic [CNT_W-1:0]    retired_cnt,
  output logic                illegal_op,
  output logic [3:0]          state
);

  localparam logic [OPCODE_W-1:0] OP_R   = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_BEQ = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_LW  = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_SW  = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_J   = OPCODE_W'(4);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC     = 4'd6,
    R_WB     = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    TRAP     = 4'd10
  } state_t;

  state_t              cur, nxt;
  logic [OPCODE_W-1:0] op_q;

  assign state = cur;

  // State register, opcode latch and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur         <= FETCH;
      op_q        <= '0;
      retired_cnt <= '0;
    end else begin
      cur <= nxt;
      if (cur == DECODE) op_q <= Inst_opcode;
      if (instr_done) retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

`ifdef ILLEGAL_TRAP_EN
  // Sticky illegal-opcode flag, set on the DECODE->TRAP transition.
  always_ff @(posedge clk) begin
    if (rst) illegal_op <= 1'b0;
    else if (cur == DECODE && nxt == TRAP) illegal_op <= 1'b1;
  end
`else
  assign illegal_op = 1'b0;
`endif

  // Next-state and Moore output decode; reset forces every strobe low.
  // The only opcode-dependent output is instr_done for the illegal-opcode NOP,
  // which must retire in DECODE itself before op_q is available.
  always_comb begin
    nxt         = cur;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 2'b00;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    instr_done  = 1'b0;
    case (cur)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) nxt = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b10;
        case (Inst_opcode)
          OP_R:         nxt = EXEC;
          OP_BEQ:       nxt = BRANCH;
          OP_LW, OP_SW: nxt = MEM_ADDR;
          OP_J:         nxt = JUMP;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            nxt = TRAP;
`else
            nxt        = FETCH;
            instr_done = 1'b1;
`endif
          end
        endcase
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = (op_q == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) nxt = MEM_WB;
      end
      MEM_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 2'b01;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      MEM_WR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) nxt = FETCH;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        nxt     = R_WB;
      end
      R_WB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
        nxt         = FETCH;
      end
      JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      TRAP:    nxt = TRAP;
      default: nxt = FETCH;
    endcase
    if (rst) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      IRWrite     = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 2'b00;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      PCSource    = 2'b00;
      instr_done  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: directed vector table,
// hand-written corner sequences, and randomized stimulus against a
// per-instruction path model.
module tb_multicycle_control_fsm;

  localparam logic [5:0] G = 6'h3F;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Inst_opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite;
  logic [1:0] MemtoReg;
  logic       RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic       instr_done;
  logic [7:0] retired_cnt;
  logic       illegal_op;
  logic [3:0] state;
  logic [17:0] outs;

  int checks   = 0;
  int failures = 0;

  multicycle_control_fsm #(.OPCODE_W(6), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .Inst_opcode(Inst_opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .IRWrite(IRWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .instr_done(instr_done), .retired_cnt(retired_cnt),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  assign outs = {PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemtoReg,
                 RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done};

  // Output table by state number, written straight from the state descriptions.
  function automatic logic [17:0] exp_outs(int st, bit mr, bit done, bit r);
    bit pcw = 0, pcwc = 0, iord = 0, irw = 0, mrd = 0, mwr = 0;
    bit regdst = 0, regw = 0, asa = 0;
    logic [1:0] m2r = 2'b00, asb = 2'b00, aop = 2'b00, psrc = 2'b00;
    if (!r) begin
      case (st)
        0: begin mrd = 1; irw = mr; pcw = mr; asb = 2'b01; end
        1: asb = 2'b10;
        2: begin asa = 1; asb = 2'b10; end
        3: begin mrd = 1; iord = 1; end
        4: begin regw = 1; m2r = 2'b01; end
        5: begin mwr = 1; iord = 1; end
        6: begin asa = 1; aop = 2'b10; end
        7: begin regw = 1; regdst = 1; end
        8: begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
        9: begin pcw = 1; psrc = 2'b10; end
        default: ;
      endcase
    end
    return {pcw, pcwc, iord, irw, mrd, mwr, m2r, regdst, regw, asa, asb, aop, psrc,
            done & ~r};
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(bit r, logic [5:0] op, bit mr);
    @(negedge clk);
    rst = r; Inst_opcode = op; mem_ready = mr;
    #1;
  endtask

  task automatic check_cycle(string tag, int st, bit done, int cnt, bit ill);
    check($sformatf("%s.state", tag), 32'(state), st);
    check($sformatf("%s.outs", tag), 32'(outs), 32'(exp_outs(st, mem_ready, done, rst)));
    check($sformatf("%s.cnt", tag), 32'(retired_cnt), cnt);
    check($sformatf("%s.illegal", tag), 32'(illegal_op), 32'(ill));
  endtask

  typedef struct {
    bit         r;
    logic [5:0] op;
    bit         mr;
    int         st;
    bit         done;
    int         cnt;
  } vec_t;

  function automatic vec_t mk(bit r, logic [5:0] op, bit mr, int st, bit done, int cnt);
    vec_t v;
    v.r = r; v.op = op; v.mr = mr; v.st = st; v.done = done; v.cnt = cnt;
    return v;
  endfunction

  // Randomized-phase model: each instruction is a list of states it visits.
  typedef struct {
    int st;
    bit wt;
    bit last;
  } step_t;

  step_t      path[$];
  int         mcnt;
  bit         mill;
  logic [5:0] cur_op;
  bit         cur_illegal;

  function automatic step_t sp(int st, bit wt, bit last);
    step_t s;
    s.st = st; s.wt = wt; s.last = last;
    return s;
  endfunction

  task automatic new_instr();
    int k = $urandom_range(0, 9);
    case (k)
      0, 1:    cur_op = 6'd0;
      2, 3:    cur_op = 6'd1;
      4, 5:    cur_op = 6'd2;
      6, 7:    cur_op = 6'd3;
      8:       cur_op = 6'd4;
      default: cur_op = 6'($urandom_range(5, 63));
    endcase
    cur_illegal = (k == 9);
    path.push_back(sp(0, 1, 0));
    case (cur_op)
      6'd0: begin path.push_back(sp(1, 0, 0)); path.push_back(sp(6, 0, 0)); path.push_back(sp(7, 0, 1)); end
      6'd1: begin path.push_back(sp(1, 0, 0)); path.push_back(sp(8, 0, 1)); end
      6'd2: begin path.push_back(sp(1, 0, 0)); path.push_back(sp(2, 0, 0));
                  path.push_back(sp(3, 1, 0)); path.push_back(sp(4, 0, 1)); end
      6'd3: begin path.push_back(sp(1, 0, 0)); path.push_back(sp(2, 0, 0)); path.push_back(sp(5, 1, 1)); end
      6'd4: begin path.push_back(sp(1, 0, 0)); path.push_back(sp(9, 0, 1)); end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        path.push_back(sp(1, 0, 0));
        path.push_back(sp(10, 1, 0));
`else
        path.push_back(sp(1, 0, 1));
`endif
      end
    endcase
  endtask

  initial begin
    vec_t vt[$];
    int   mw_cycles = 0;
    int   done_cycles = 0;

    rst = 1'b1; mem_ready = 1'b1; Inst_opcode = '0;

    // Reset, LW, SW with write stalls, R/BEQ/J back-to-back, LW with stalls.
    vt.push_back(mk(1, G, 1, 0, 0, 0));
    vt.push_back(mk(1, G, 1, 0, 0, 0));
    vt.push_back(mk(0, G, 1, 0, 0, 0));
    vt.push_back(mk(0, 2, 1, 1, 0, 0));
    vt.push_back(mk(0, G, 1, 2, 0, 0));
    vt.push_back(mk(0, G, 1, 3, 0, 0));
    vt.push_back(mk(0, G, 1, 4, 1, 0));
    vt.push_back(mk(0, G, 1, 0, 0, 1));
    vt.push_back(mk(0, 3, 1, 1, 0, 1));
    vt.push_back(mk(0, G, 1, 2, 0, 1));
    vt.push_back(mk(0, G, 0, 5, 0, 1));
    vt.push_back(mk(0, G, 0, 5, 0, 1));
    vt.push_back(mk(0, G, 0, 5, 0, 1));
    vt.push_back(mk(0, G, 1, 5, 1, 1));
    vt.push_back(mk(0, G, 1, 0, 0, 2));
    vt.push_back(mk(0, 0, 1, 1, 0, 2));
    vt.push_back(mk(0, G, 1, 6, 0, 2));
    vt.push_back(mk(0, G, 1, 7, 1, 2));
    vt.push_back(mk(0, G, 1, 0, 0, 3));
    vt.push_back(mk(0, 1, 1, 1, 0, 3));
    vt.push_back(mk(0, G, 1, 8, 1, 3));
    vt.push_back(mk(0, G, 1, 0, 0, 4));
    vt.push_back(mk(0, 4, 1, 1, 0, 4));
    vt.push_back(mk(0, G, 1, 9, 1, 4));
    vt.push_back(mk(0, G, 0, 0, 0, 5));
    vt.push_back(mk(0, G, 1, 0, 0, 5));
    vt.push_back(mk(0, 2, 1, 1, 0, 5));
    vt.push_back(mk(0, G, 1, 2, 0, 5));
    vt.push_back(mk(0, G, 0, 3, 0, 5));
    vt.push_back(mk(0, G, 1, 3, 0, 5));
    vt.push_back(mk(0, G, 1, 4, 1, 5));
    vt.push_back(mk(0, G, 1, 0, 0, 6));

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].r, vt[i].op, vt[i].mr);
      check_cycle($sformatf("vec%0d", i), vt[i].st, vt[i].done, vt[i].cnt, 1'b0);
      if (MemWrite === 1'b1) mw_cycles++;
      if (instr_done === 1'b1) done_cycles++;
      if (i == 23) check("jump_pcsource", 32'(PCSource), 32'h2);
      if (i == 6)  check("lw_memtoreg", 32'(MemtoReg), 32'h1);
    end
    check("sw_memwrite_cycles", mw_cycles, 4);
    check("table_retires", done_cycles, 6);

    // Illegal opcode in DECODE.
    drive(0, G, 1);
`ifdef ILLEGAL_TRAP_EN
    check_cycle("ill_dec", 1, 0, 6, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 6'($urandom), 1'($urandom));
      check_cycle($sformatf("trap%0d", i), 10, 0, 6, 1);
    end
    drive(1, G, 1);
    check_cycle("trap_rst", 10, 0, 6, 1);
`else
    check_cycle("ill_dec", 1, 1, 6, 0);
    drive(0, G, 1);
    check_cycle("ill_after", 0, 0, 7, 0);
    drive(1, G, 1);
    check_cycle("nop_rst", 1, 0, 7, 0);
`endif
    drive(0, G, 1);
    check_cycle("post_rst", 0, 0, 0, 0);

    // One J to make the counter nonzero, then reset in the middle of an LW.
    drive(0, 4, 1); check_cycle("j_dec", 1, 0, 0, 0);
    drive(0, G, 1); check_cycle("j_jump", 9, 1, 0, 0);
    drive(0, G, 1); check_cycle("lw_fetch", 0, 0, 1, 0);
    drive(0, 2, 1); check_cycle("lw_dec", 1, 0, 1, 0);
    drive(0, G, 1); check_cycle("lw_addr", 2, 0, 1, 0);
    drive(1, G, 1); check_cycle("lw_rd_rst", 3, 0, 1, 0);
    drive(0, G, 1); check_cycle("abort_fetch", 0, 0, 0, 0);

    // Counter wrap: 256 J instructions take the 8-bit count back to 0.
    for (int i = 0; i < 256; i++) begin
      drive(0, 4, 1); check_cycle($sformatf("wrap%0d.dec", i), 1, 0, i, 0);
      drive(0, G, 1); check_cycle($sformatf("wrap%0d.jmp", i), 9, 1, i, 0);
      drive(0, G, 1); check_cycle($sformatf("wrap%0d.fet", i), 0, 0, (i + 1) % 256, 0);
    end

    // Randomized phase against the path model.
    drive(1, G, 1);
    path.delete(); mcnt = 0; mill = 0; new_instr();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bit r, mr, edone;
      logic [5:0] op;
      r  = ($urandom_range(0, 99) == 0) || (mill && $urandom_range(0, 9) == 0);
      mr = ($urandom_range(0, 99) < 70);
      op = (path[0].st == 1) ? cur_op : 6'($urandom);
      drive(r, op, mr);
      edone = !r && path[0].last && (!path[0].wt || mr);
      check_cycle($sformatf("rnd%0d", cyc), path[0].st, edone, mcnt, mill);
      if (r) begin
        path.delete(); mcnt = 0; mill = 0; new_instr();
      end else begin
        if (edone) mcnt = (mcnt + 1) % 256;
        if (path[0].st != 10 && !(path[0].wt && !mr)) begin
`ifdef ILLEGAL_TRAP_EN
          if (path[0].st == 1 && cur_illegal) mill = 1;
`endif
          void'(path.pop_front());
          if (path.size() == 0) new_instr();
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
